sram_loader: RTL and testbench
==============================

Name: sram_loader

Overview:
- Writes note instructions into the external 16-bit SRAM. This is the writer-side counterpart of the instruction fetch in `cpu`, which only reads SRAM.
- Accepts a byte stream from an upstream byte source (UART receiver or host bridge) over a valid/ready handshake.
- Packs two bytes into each 16-bit instruction word and writes the words to consecutive SRAM addresses starting at 0.
- Asserts `busy` while loading so the sequencer can be held off the SRAM bus.

Parameters:
- ADDR_W, 18, SRAM address width; the address space holds 2**ADDR_W words.
- WE_CYCLES, 2, number of clock cycles SRAM_WE is held low per write; minimum value 1.
- END_WORD, 16'hFFFF, terminator word; it is written to SRAM and then ends the load.

Ports:
- CLK  in  1  system clock, 50 MHz.
- RST_N  in  1  asynchronous reset, active low.
- start  in  1  single-cycle pulse that begins a load.
- in_byte  in  8  incoming byte.
- in_valid  in  1  in_byte is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- SRAM_A  out  ADDR_W  SRAM address.
- SRAM_DQ_O  out  16  write data.
- SRAM_DQ_OE  out  1  top level drives the SRAM data pins with SRAM_DQ_O when this is 1.
- SRAM_D  in  16  SRAM read data (used only with the optional feature).
- SRAM_WE, SRAM_OE, SRAM_CE, SRAM_LB, SRAM_UB  out  1 each  active-low SRAM controls.
- busy  out  1  load in progress.
- done  out  1  load finished; sticky until the next start.
- overflow  out  1  address space exhausted before END_WORD arrived.
- word_count  out  ADDR_W+1  number of words written, including END_WORD.

Behaviour:
- Reset values (async on RST_N low): state IDLE; SRAM_WE=1, SRAM_OE=1, SRAM_DQ_OE=0, SRAM_A=0, SRAM_DQ_O=0; busy=0, done=0, overflow=0, word_count=0, in_ready=0.
- SRAM_CE, SRAM_LB and SRAM_UB are tied to 0 at all times.
- State IDLE / DONE:
  - On start: clear addr, word_count, done and overflow; set busy=1; go to GET_HI.
  - start is ignored in every other state.
- GET_HI: in_ready=1. When in_valid and in_ready are both 1, latch the byte as the high byte; go to GET_LO.
- GET_LO: in_ready=1. On a handshake, latch the low byte; word = {hi, lo}. Go to SETUP.
- SETUP (1 cycle):
  - SRAM_A=addr, SRAM_DQ_O=word, SRAM_DQ_OE=1, SRAM_WE=1.
  - If addr==2**ADDR_W, address space is full: set overflow=1, done=1, busy=0, SRAM_DQ_OE=0; go to DONE without writing.
- WRITE (WE_CYCLES cycles): SRAM_WE=0; address and data held stable.
- HOLD (1 cycle):
  - SRAM_WE=1 with data still driven.
  - At the end of HOLD: word_count+1, addr+1.
  - If word==END_WORD: done=1, busy=0; go to DONE. Otherwise go to GET_HI.
- Timing and bus rules:
  - in_ready is 0 in SETUP, WRITE, HOLD and DONE, so an upstream byte waits and no byte is dropped.
  - Minimum cadence is one word per 4+WE_CYCLES cycles.
  - SRAM_WE falls 2 cycles after the low-byte handshake.
  - SRAM_DQ_OE deasserts the cycle after HOLD.
  - SRAM_DQ_OE and SRAM_OE=0 are never asserted in the same cycle.
- Address counter is ADDR_W+1 bits wide so it can reach 2**ADDR_W without wrapping. SRAM_A outputs addr[ADDR_W-1:0].
- A partial word (only the high byte received) is discarded if RST_N is asserted.
- Reset asserted mid-write forces SRAM_WE=1 and SRAM_DQ_OE=0 immediately, because reset is asynchronous.

Optional Feature:
- Macro: SRAM_LOADER_VERIFY_EN.
- Defined:
  - After HOLD, insert state VRD for 2 cycles: SRAM_DQ_OE=0, SRAM_OE=0, same address.
  - At the end of VRD, compare SRAM_D with word. On mismatch set the sticky output verify_err=1 (reset 0, cleared by start). The load continues either way.
  - Cadence becomes 6+WE_CYCLES cycles per word.
- Undefined: no VRD state; the verify_err port does not exist; SRAM_D is unused.

Decomposition:
- Package sram_pkg holds:
  - the state enum;
  - END_WORD_DEFAULT;
  - the SRAM control polarity constants (SRAM_ASSERT=0, SRAM_DEASSERT=1);
  - the instruction field offsets shared with the sequencer (note [3:0], octave [5:4]).
- Sub-module sram_wr_timer: a down-counter that generates the WE_CYCLES-long low pulse.

Test Plan:
- start; bytes 12,34,FF,FF with in_valid held high:
  - writes 0x1234 to addr 0 and 0xFFFF to addr 1;
  - SRAM_WE low for exactly 2 cycles per write;
  - done=1, word_count=2, busy=0.
- Byte 0xAB with in_valid=1, followed by a 5-cycle in_valid=0 gap before 0xCD: in_ready tracks state, no duplicate capture, 0xABCD written once.
- ADDR_W=3; 9 non-terminator words:
  - 8 writes to addresses 0..7;
  - 9th word reaches SETUP with addr=8, nothing written, overflow=1, done=1, word_count=8.
- Reset pulse during WRITE:
  - SRAM_WE=1 and SRAM_DQ_OE=0 within the same cycle;
  - after release, all outputs at their reset values; the next start begins at addr 0.
- start pulsed while busy: ignored. start pulsed in DONE: done, overflow and word_count cleared; loading restarts at addr 0.
- With SRAM_LOADER_VERIFY_EN, SRAM model corrupting bit 0 on addr 1: verify_err rises after the second word, and the load completes normally.

Source files
------------

// File: rtl/sram_pkg.sv
// ----------------------------------------------------------------------------
// sram_pkg -- shared definitions for the SRAM instruction loader.
//
// Contents:
//   ld_state_t        loader FSM state encoding
//   END_WORD_DEFAULT  default terminator word that ends a load
//   SRAM_ASSERT /     polarity of the active-low SRAM control strobes
//   SRAM_DEASSERT
//   NOTE_* / OCT_*    instruction field offsets shared with the sequencer
//   instr_note()      extract the note field of an instruction word
//   instr_octave()    extract the octave field of an instruction word
// ----------------------------------------------------------------------------
package sram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GET_HI = 3'd1,
    ST_GET_LO = 3'd2,
    ST_SETUP  = 3'd3,
    ST_WRITE  = 3'd4,
    ST_HOLD   = 3'd5,
    ST_VRD    = 3'd6,
    ST_DONE   = 3'd7
  } ld_state_t;

  localparam logic [15:0] END_WORD_DEFAULT = 16'hFFFF;

  // SRAM strobes are active low.
  localparam logic SRAM_ASSERT   = 1'b0;
  localparam logic SRAM_DEASSERT = 1'b1;

  // Instruction word layout as decoded by the sequencer.
  localparam int NOTE_LSB = 0;
  localparam int NOTE_MSB = 3;
  localparam int OCT_LSB  = 4;
  localparam int OCT_MSB  = 5;

  function automatic logic [NOTE_MSB-NOTE_LSB:0] instr_note(input logic [15:0] w);
    return w[NOTE_MSB:NOTE_LSB];
  endfunction

  function automatic logic [OCT_MSB-OCT_LSB:0] instr_octave(input logic [15:0] w);
    return w[OCT_MSB:OCT_LSB];
  endfunction

endpackage

// File: rtl/sram_wr_timer.sv
// ----------------------------------------------------------------------------
// sram_wr_timer -- down-counter that times the SRAM write-enable low pulse.
//
// A one-cycle 'load' arms the counter with WE_CYCLES; 'last' is high during
// the final cycle of the pulse so the FSM can release SRAM_WE on that edge.
//
// Ports:
//   CLK    in   system clock
//   RST_N  in   asynchronous reset, active low
//   load   in   arm the counter (cycle before the first WE-low cycle)
//   last   out  current cycle is the last WE-low cycle
// ----------------------------------------------------------------------------
module sram_wr_timer #(
  parameter int WE_CYCLES = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic load,
  output logic last
);

  localparam int CNT_W = $clog2(WE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WE_CYCLES);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign last = (cnt == ONE);

endmodule

// File: rtl/sram_loader.sv
// ----------------------------------------------------------------------------
// sram_loader -- packs a byte stream into 16-bit instruction words and writes
// them to consecutive external SRAM addresses starting at 0. The load ends
// after the terminator word END_WORD has been written, or when the address
// space is exhausted (overflow).
//
// Optional build macro: SRAM_LOADER_VERIFY_EN
//   When defined, every write is followed by a two-cycle read-back (state
//   VRD); a mismatch sets the sticky verify_err output. When undefined there
//   is no read-back, no verify_err port, and SRAM_D is ignored.
//
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   start               one-cycle pulse, begins a load from IDLE/DONE
//   in_byte, in_valid,  upstream byte stream (valid/ready handshake)
//   in_ready
//   SRAM_A, SRAM_DQ_O,  SRAM address, write data, data-pin drive enable
//   SRAM_DQ_OE
//   SRAM_D              SRAM read data (read-back only)
//   SRAM_WE/OE/CE/LB/UB active-low SRAM strobes (CE/LB/UB tied asserted)
//   busy, done,         load in progress / finished (sticky) /
//   overflow            address space exhausted
//   verify_err          read-back mismatch seen (SRAM_LOADER_VERIFY_EN only)
//   word_count          words written, including the terminator
// ----------------------------------------------------------------------------
module sram_loader
  import sram_pkg::*;
#(
  parameter int          ADDR_W    = 18,
  parameter int          WE_CYCLES = 2,
  parameter logic [15:0] END_WORD  = END_WORD_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] SRAM_A,
  output logic [15:0]       SRAM_DQ_O,
  output logic              SRAM_DQ_OE,
  input  logic [15:0]       SRAM_D,
  output logic              SRAM_WE,
  output logic              SRAM_OE,
  output logic              SRAM_CE,
  output logic              SRAM_LB,
  output logic              SRAM_UB,
  output logic              busy,
  output logic              done,
  output logic              overflow,
`ifdef SRAM_LOADER_VERIFY_EN
  output logic              verify_err,
`endif
  output logic [ADDR_W:0]   word_count
);

  // One past the last word; addr is ADDR_W+1 bits so it can hold this value.
  localparam logic [ADDR_W:0] FULL_ADDR = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ADDR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  ld_state_t         state;
  logic [ADDR_W:0]   addr;
  logic [7:0]        hi_byte;
  logic [15:0]       word;
  logic              we_load;
  logic              we_last;
`ifdef SRAM_LOADER_VERIFY_EN
  logic              vrd_last;
`else
  logic [15:0]       unused_sram_d;
  assign unused_sram_d = SRAM_D;
`endif

  // Whole device selected, both byte lanes enabled, permanently.
  assign SRAM_CE = SRAM_ASSERT;
  assign SRAM_LB = SRAM_ASSERT;
  assign SRAM_UB = SRAM_ASSERT;

  // Arm the pulse timer on the SETUP edge that really starts a write.
  assign we_load = (state == ST_SETUP) && (addr != FULL_ADDR);

  sram_wr_timer #(
    .WE_CYCLES (WE_CYCLES)
  ) u_wr_timer (
    .CLK   (CLK),
    .RST_N (RST_N),
    .load  (we_load),
    .last  (we_last)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      addr       <= '0;
      hi_byte    <= '0;
      word       <= '0;
      in_ready   <= 1'b0;
      SRAM_A     <= '0;
      SRAM_DQ_O  <= '0;
      SRAM_DQ_OE <= 1'b0;
      SRAM_WE    <= SRAM_DEASSERT;
      SRAM_OE    <= SRAM_DEASSERT;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
`ifdef SRAM_LOADER_VERIFY_EN
      verify_err <= 1'b0;
      vrd_last   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            addr       <= '0;
            word_count <= '0;
            done       <= 1'b0;
            overflow   <= 1'b0;
`ifdef SRAM_LOADER_VERIFY_EN
            verify_err <= 1'b0;
`endif
            busy       <= 1'b1;
            in_ready   <= 1'b1;
            state      <= ST_GET_HI;
          end
        end

        ST_GET_HI: begin
          if (in_valid && in_ready) begin
            hi_byte <= in_byte;
            state   <= ST_GET_LO;
          end
        end

        // Address and data are registered here so they are already stable
        // on the bus during SETUP. A full address space never drives the bus.
        ST_GET_LO: begin
          if (in_valid && in_ready) begin
            word       <= {hi_byte, in_byte};
            SRAM_DQ_O  <= {hi_byte, in_byte};
            SRAM_A     <= addr[ADDR_W-1:0];
            SRAM_DQ_OE <= (addr != FULL_ADDR);
            in_ready   <= 1'b0;
            state      <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (addr == FULL_ADDR) begin
            overflow   <= 1'b1;
            done       <= 1'b1;
            busy       <= 1'b0;
            SRAM_DQ_OE <= 1'b0;
            state      <= ST_DONE;
          end else begin
            SRAM_WE <= SRAM_ASSERT;
            state   <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          if (we_last) begin
            SRAM_WE <= SRAM_DEASSERT;
            state   <= ST_HOLD;
          end
        end

        // WE is already high; data stays driven one more cycle for hold time.
        ST_HOLD: begin
          word_count <= word_count + ADDR_ONE;
          addr       <= addr + ADDR_ONE;
          SRAM_DQ_OE <= 1'b0;
`ifdef SRAM_LOADER_VERIFY_EN
          SRAM_OE    <= SRAM_ASSERT;
          vrd_last   <= 1'b0;
          state      <= ST_VRD;
`else
          if (word == END_WORD) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end else begin
            in_ready <= 1'b1;
            state    <= ST_GET_HI;
          end
`endif
        end

`ifdef SRAM_LOADER_VERIFY_EN
        // Two-cycle read of the word just written; SRAM_A is still held.
        ST_VRD: begin
          if (!vrd_last) begin
            vrd_last <= 1'b1;
          end else begin
            SRAM_OE <= SRAM_DEASSERT;
            if (SRAM_D != word) begin
              verify_err <= 1'b1;
            end
            if (word == END_WORD) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_DONE;
            end else begin
              in_ready <= 1'b1;
              state    <= ST_GET_HI;
            end
          end
        end
`endif

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_loader.sv
`timescale 1ns/1ps
module tb_sram_loader;

  localparam int AW    = 3;
  localparam int WEC   = 2;
  localparam int DEPTH = 1 << AW;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    in_byte = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] SRAM_A;
  logic [15:0]   SRAM_DQ_O;
  logic          SRAM_DQ_OE;
  logic [15:0]   SRAM_D;
  logic          SRAM_WE, SRAM_OE, SRAM_CE, SRAM_LB, SRAM_UB;
  logic          busy, done, overflow;
  logic [AW:0]   word_count;
`ifdef SRAM_LOADER_VERIFY_EN
  logic          verify_err;
`endif

  sram_loader #(.ADDR_W(AW), .WE_CYCLES(WEC)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start),
    .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .SRAM_A(SRAM_A), .SRAM_DQ_O(SRAM_DQ_O), .SRAM_DQ_OE(SRAM_DQ_OE),
    .SRAM_D(SRAM_D), .SRAM_WE(SRAM_WE), .SRAM_OE(SRAM_OE),
    .SRAM_CE(SRAM_CE), .SRAM_LB(SRAM_LB), .SRAM_UB(SRAM_UB),
    .busy(busy), .done(done), .overflow(overflow),
`ifdef SRAM_LOADER_VERIFY_EN
    .verify_err(verify_err),
`endif
    .word_count(word_count)
  );

  always #10 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- SRAM model and bus monitor ----------------
  typedef struct {
    logic [AW-1:0] a;
    logic [15:0]   d;
    int            len;
  } wr_t;

  wr_t           wr_q[$];
  logic [15:0]   mem [0:DEPTH-1];
  bit            corrupt = 1'b0;
  int            we_len = 0;
  logic [AW-1:0] cur_a = '0;
  logic [15:0]   cur_d = '0;
  int            bus_clash = 0;
  int            unstable = 0;

  initial for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0000;

  assign SRAM_D = mem[SRAM_A] ^ ((corrupt && SRAM_A == 1) ? 16'h0001 : 16'h0000);

  always @(negedge CLK) begin
    if (SRAM_WE == 1'b0) begin
      if (we_len == 0) begin
        cur_a = SRAM_A;
        cur_d = SRAM_DQ_O;
      end else if (SRAM_A !== cur_a || SRAM_DQ_O !== cur_d) begin
        unstable++;
      end
      if (SRAM_DQ_OE !== 1'b1) unstable++;
      we_len++;
      mem[SRAM_A] = SRAM_DQ_O;
    end else if (we_len != 0) begin
      wr_q.push_back('{a: cur_a, d: cur_d, len: we_len});
      we_len = 0;
    end
    if (SRAM_DQ_OE === 1'b1 && SRAM_OE === 1'b0) bus_clash++;
  end

  // ---------------- reference model ----------------
  logic [15:0] words_q[$];
  logic [15:0] exp_q[$];
  logic [7:0]  stream_q[$];

  // Words land at 0,1,2,... until the terminator has been written or the
  // next word finds no free address.
  task automatic model(output int n, output bit ovf);
    exp_q.delete();
    n = 0;
    ovf = 1'b0;
    foreach (words_q[i]) begin
      if (n == DEPTH) begin
        ovf = 1'b1;
        break;
      end
      exp_q.push_back(words_q[i]);
      n++;
      if (words_q[i] == 16'hFFFF) break;
    end
  endtask

  task automatic prep();
    stream_q.delete();
    foreach (words_q[i]) begin
      stream_q.push_back(words_q[i][15:8]);
      stream_q.push_back(words_q[i][7:0]);
    end
    wr_q.delete();
    bus_clash = 0;
    unstable = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  // Offers stream_q bytes with optional random idle gaps; called at posedge+1.
  task automatic feed(input int gap_max);
    int idx = 0;
    int budget = 0;
    bit hs;
    while (idx < stream_q.size() && budget < 3000) begin
      if (done === 1'b1) break;
      if (gap_max > 0 && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, gap_max)) begin
          @(posedge CLK); #1;
          budget++;
        end
      end
      in_valid = 1'b1;
      in_byte  = stream_q[idx];
      @(negedge CLK);
      hs = (in_ready === 1'b1);
      @(posedge CLK); #1;
      budget++;
      if (hs) idx++;
    end
    in_valid = 1'b0;
    if (budget >= 3000) check("feed budget", 32'(budget), 32'(0));
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (done !== 1'b1 && c < budget) begin
      @(posedge CLK); #1;
      c++;
    end
  endtask

  task automatic finish_load(input string tag);
    int n;
    bit ovf;
    model(n, ovf);
    wait_done(1000);
    @(negedge CLK);
    check({tag, " done"}, done, 1);
    check({tag, " busy"}, busy, 0);
    check({tag, " overflow"}, overflow, ovf);
    check({tag, " word_count"}, word_count, n);
    check({tag, " writes"}, wr_q.size(), n);
    for (int i = 0; i < n && i < wr_q.size(); i++) begin
      check({tag, " wr addr"}, wr_q[i].a, i);
      check({tag, " wr data"}, wr_q[i].d, exp_q[i]);
      check({tag, " we len"}, wr_q[i].len, WEC);
    end
    check({tag, " bus clash"}, bus_clash, 0);
    check({tag, " addr/data stable"}, unstable, 0);
`ifdef SRAM_LOADER_VERIFY_EN
    check({tag, " verify_err"}, verify_err, (corrupt && n >= 2));
`endif
    @(posedge CLK); #1;
  endtask

  task automatic run_load(input int gap_max, input string tag);
    prep();
    pulse_start();
    feed(gap_max);
    finish_load(tag);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " in_ready"}, in_ready, 0);
    check({tag, " WE"}, SRAM_WE, 1);
    check({tag, " OE"}, SRAM_OE, 1);
    check({tag, " DQ_OE"}, SRAM_DQ_OE, 0);
    check({tag, " A"}, SRAM_A, 0);
    check({tag, " DQ_O"}, SRAM_DQ_O, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " overflow"}, overflow, 0);
    check({tag, " word_count"}, word_count, 0);
    check({tag, " CE/LB/UB"}, {SRAM_CE, SRAM_LB, SRAM_UB}, 3'b000);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          n_words;
    logic [15:0] base;
    bit          term;
    int          gap_max;
    int          exp_wc;
    bit          exp_ovf;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1, 16'h1234, 1'b1, 0, 2, 1'b0};
    vecs[1] = '{0, 16'h0000, 1'b1, 0, 1, 1'b0};
    vecs[2] = '{7, 16'h0100, 1'b1, 3, 8, 1'b0};
    vecs[3] = '{8, 16'h0200, 1'b1, 2, 8, 1'b1};
    vecs[4] = '{9, 16'h0300, 1'b0, 0, 8, 1'b1};
    vecs[5] = '{3, 16'h8000, 1'b1, 2, 4, 1'b0};

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_vals("reset");
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Byte gap: AB, five idle cycles, CD
    words_q = '{16'hABCD, 16'hFFFF};
    prep();
    pulse_start();
    in_valid = 1'b1;
    in_byte  = 8'hAB;
    @(negedge CLK);
    check("gap ready hi", in_ready, 1);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    repeat (5) begin
      @(negedge CLK);
      check("gap ready idle", in_ready, 1);
      @(posedge CLK); #1;
    end
    in_valid = 1'b1;
    in_byte  = 8'hCD;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    @(negedge CLK);
    check("setup in_ready", in_ready, 0);
    check("setup WE", SRAM_WE, 1);
    check("setup DQ_OE", SRAM_DQ_OE, 1);
    check("setup A", SRAM_A, 0);
    check("setup DQ_O", SRAM_DQ_O, 16'hABCD);
    @(negedge CLK);
    check("WE falls 2 cycles after lo", SRAM_WE, 0);
    @(posedge CLK); #1;
    void'(stream_q.pop_front());
    void'(stream_q.pop_front());
    feed(0);
    finish_load("gap");

    // Table of whole loads
    foreach (vecs[v]) begin
      words_q.delete();
      for (int i = 0; i < vecs[v].n_words; i++) words_q.push_back(vecs[v].base + 16'(i));
      if (vecs[v].term) words_q.push_back(16'hFFFF);
      run_load(vecs[v].gap_max, $sformatf("vec%0d", v));
      check($sformatf("vec%0d table wc", v), word_count, vecs[v].exp_wc);
      check($sformatf("vec%0d table ovf", v), overflow, vecs[v].exp_ovf);
    end

    // start in DONE (previous load overflowed): flags cleared, restart at 0
    words_q = '{16'h2345, 16'hFFFF};
    prep();
    pulse_start();
    @(negedge CLK);
    check("restart done", done, 0);
    check("restart overflow", overflow, 0);
    check("restart word_count", word_count, 0);
    check("restart busy", busy, 1);
    @(posedge CLK); #1;
    feed(0);
    finish_load("restart");

    // start while busy is ignored
    words_q = '{16'hA1B2, 16'hFFFF};
    prep();
    pulse_start();
    in_valid = 1'b1;
    in_byte  = 8'hA1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    pulse_start();
    void'(stream_q.pop_front());
    feed(0);
    finish_load("busy start");

    // Reset during WRITE
    words_q = '{16'h5566, 16'hFFFF};
    prep();
    pulse_start();
    in_valid = 1'b1;
    in_byte  = 8'h55;
    @(posedge CLK); #1;
    in_byte  = 8'h66;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    @(posedge CLK); #1;
    check("pre-reset WE", SRAM_WE, 0);
    #4;
    RST_N = 1'b0;
    #1;
    check("async reset WE", SRAM_WE, 1);
    check("async reset DQ_OE", SRAM_DQ_OE, 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(negedge CLK);
    check_reset_vals("post-reset");
    @(posedge CLK); #1;
    words_q = '{16'h1234, 16'hFFFF};
    run_load(0, "after reset");

`ifdef SRAM_LOADER_VERIFY_EN
    corrupt = 1'b1;
    words_q = '{16'h1111, 16'h2222, 16'hFFFF};
    run_load(0, "verify corrupt");
    corrupt = 1'b0;
    words_q = '{16'h3333, 16'h4444, 16'hFFFF};
    run_load(0, "verify clean");
`endif

    // Randomized loads against the model
    for (int r = 0; r < 12; r++) begin
      int n;
      n = $urandom_range(0, 10);
      words_q.delete();
      for (int i = 0; i < n; i++) words_q.push_back(16'($urandom));
      words_q.push_back(16'hFFFF);
      run_load($urandom_range(0, 3), $sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
